// File: rtl/mem_arbiter.sv
// Bus arbiter parking on the CPU; DMA steals cycles with priority, capped at MAX_BURST
// consecutive cycles while the CPU waits. Optional stall counter under `ARB_STATS_EN`.
module mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_in,
    input  logic [15:0] cpu_a_in,
    input  logic [15:0] cpu_d_in,
    input  logic        cpu_wen_in,
    input  logic        cpu_iom_in,
    input  logic        dma_req_in,
    input  logic [15:0] dma_a_in,
    input  logic [15:0] dma_d_in,
    input  logic        dma_wen_in,
    input  logic        dma_iom_in,
`ifdef ARB_STATS_EN
    input  logic        stats_clr_in,
    output logic [15:0] stall_cnt_out,
`endif
    output logic        cpu_gnt_out,
    output logic        cpu_stall_out,
    output logic        dma_gnt_out,
    output logic [15:0] mem_a_out,
    output logic [15:0] mem_d_out,
    output logic        mem_wen_out,
    output logic        mem_iom_out
);
    typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = (dma_req_in && !cpu_req_in) ? DMA : CPU;
                cnt_nxt   = 4'd0;
            end
            CPU: begin
                if (dma_req_in) begin
                    state_nxt = DMA;
                    cnt_nxt   = 4'd0;
                end
            end
            DMA: begin
                // cnt saturates so a CPU request arriving late still reclaims the bus at once
                if (!dma_req_in || (cpu_req_in && cnt == CNT_LAST)) begin
                    state_nxt = CPU;
                    cnt_nxt   = 4'd0;
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        cpu_gnt_out = 1'b0;
        dma_gnt_out = 1'b0;
        mem_a_out   = 16'd0;
        mem_d_out   = 16'd0;
        mem_wen_out = 1'b0;
        mem_iom_out = 1'b0;
        case (state)
            CPU: begin
                cpu_gnt_out = 1'b1;
                mem_a_out   = cpu_a_in;
                mem_d_out   = cpu_d_in;
                mem_wen_out = cpu_wen_in & cpu_req_in;
                mem_iom_out = cpu_iom_in;
            end
            DMA: begin
                dma_gnt_out = 1'b1;
                mem_a_out   = dma_a_in;
                mem_d_out   = dma_d_in;
                mem_wen_out = dma_wen_in & dma_req_in;
                mem_iom_out = dma_iom_in;
            end
            default: ;
        endcase
    end

    assign cpu_stall_out = cpu_req_in & ~cpu_gnt_out;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_out <= 16'd0;
        else if (stats_clr_in)
            stall_cnt_out <= 16'd0;
        else if (cpu_stall_out && stall_cnt_out != 16'hFFFF)
            stall_cnt_out <= stall_cnt_out + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against an ownership/run-length reference model.
module tb_mem_arbiter;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wen, cpu_iom, dma_req, dma_wen, dma_iom;
    logic [15:0] cpu_a, cpu_d, dma_a, dma_d;
    logic        cpu_gnt, cpu_stall, dma_gnt, mem_wen, mem_iom;
    logic [15:0] mem_a, mem_d;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_in(cpu_req), .cpu_a_in(cpu_a), .cpu_d_in(cpu_d),
        .cpu_wen_in(cpu_wen), .cpu_iom_in(cpu_iom),
        .dma_req_in(dma_req), .dma_a_in(dma_a), .dma_d_in(dma_d),
        .dma_wen_in(dma_wen), .dma_iom_in(dma_iom),
`ifdef ARB_STATS_EN
        .stats_clr_in(stats_clr), .stall_cnt_out(stall_cnt),
`endif
        .cpu_gnt_out(cpu_gnt), .cpu_stall_out(cpu_stall), .dma_gnt_out(dma_gnt),
        .mem_a_out(mem_a), .mem_d_out(mem_d), .mem_wen_out(mem_wen), .mem_iom_out(mem_iom)
    );

    int checks = 0;
    int failures = 0;

    // Reference: who owns the bus (0 none, 1 CPU, 2 DMA) and how many cycles DMA has held it.
    int          m_owner = 0;
    int          m_run   = 0;
    int          m_scnt  = 0;
    logic [15:0] exp_mem [0:65535];
    logic [15:0] dut_mem [0:65535];

    logic        o_cgnt, o_dgnt, o_stall, o_wen;
    logic [15:0] o_a;
    int          o_scnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int          own;
        logic        e_wen, e_iom, e_stall;
        logic [15:0] e_a, e_d;
        @(negedge clk);
        own = rst ? 0 : m_owner;
        e_a = 16'd0; e_d = 16'd0; e_wen = 1'b0; e_iom = 1'b0;
        if (own == 1) begin
            e_a = cpu_a; e_d = cpu_d; e_wen = cpu_wen && cpu_req; e_iom = cpu_iom;
        end else if (own == 2) begin
            e_a = dma_a; e_d = dma_d; e_wen = dma_wen && dma_req; e_iom = dma_iom;
        end
        e_stall = cpu_req && (own != 1);
        o_cgnt = cpu_gnt; o_dgnt = dma_gnt; o_stall = cpu_stall; o_wen = mem_wen; o_a = mem_a;
        check("grant", {61'd0, cpu_gnt, dma_gnt, cpu_stall}, {61'd0, own == 1, own == 2, e_stall});
        check("bus", {30'd0, mem_a, mem_d, mem_wen, mem_iom}, {30'd0, e_a, e_d, e_wen, e_iom});
        if (mem_wen) dut_mem[mem_a] = mem_d;
        if (e_wen) exp_mem[e_a] = e_d;
`ifdef ARB_STATS_EN
        if (rst) m_scnt = 0;
        o_scnt = int'(stall_cnt);
        check("stall_cnt", {48'd0, stall_cnt}, 64'(m_scnt));
        if (rst || stats_clr) m_scnt = 0;
        else if (e_stall && m_scnt < 65535) m_scnt++;
`else
        o_scnt = 0;
`endif
        if (rst) begin
            m_owner = 0;
        end else if (own == 0) begin
            m_owner = (dma_req && !cpu_req) ? 2 : 1;
            m_run   = 1;
        end else if (own == 1) begin
            if (dma_req) begin m_owner = 2; m_run = 1; end
        end else begin
            if (!dma_req || (cpu_req && m_run >= MAX_BURST)) m_owner = 1;
            else m_run++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          stalls;
        int          nmis;
        int          pc, pd;
        logic [15:0] vals [10];

        for (int i = 0; i < 65536; i++) begin exp_mem[i] = 16'd0; dut_mem[i] = 16'd0; end
        rst = 1'b1;
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_iom = 1'b0; cpu_a = 16'h0040; cpu_d = 16'h5555;
        dma_req = 1'b0; dma_wen = 1'b0; dma_iom = 1'b0; dma_a = 16'h0; dma_d = 16'h0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;

        // Reset with CPU requesting a write
        step();
        check("rst_gnt", {62'd0, o_cgnt, o_dgnt}, 64'd0);
        check("rst_wen", {63'd0, o_wen}, 64'd0);
        check("rst_stall", {63'd0, o_stall}, 64'd1);
        rst = 1'b0;
        cpu_wen = 1'b0;
        step();
        cpu_a = 16'h0ABC;
        step();
        check("post_rst_gnt", {63'd0, o_cgnt}, 64'd1);
        check("post_rst_addr", {48'd0, o_a}, 64'h0ABC);

        // CPU only: ten writes with no stalls
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_a = 16'h0040 + 16'(i); cpu_d = 16'($urandom); cpu_wen = 1'b1; vals[i] = cpu_d;
            step();
            stalls += int'(o_stall);
        end
        check("cpu_only_stalls", 64'(stalls), 64'd0);
        for (int i = 0; i < 10; i++)
            check("cpu_only_mem", {48'd0, dut_mem[16'h0040 + 16'(i)]}, {48'd0, vals[i]});

        // Single DMA steal
        cpu_a = 16'h0050; cpu_wen = 1'b0;
        dma_req = 1'b1; dma_a = 16'h8000; dma_d = 16'h1234; dma_wen = 1'b1;
        step();
        check("steal_cpu_first", {62'd0, o_cgnt, o_dgnt}, 64'd2);
        step();
        check("steal_dma_gnt", {62'd0, o_dgnt, o_wen}, 64'd3);
        check("steal_dma_addr", {48'd0, o_a}, 64'h8000);
        dma_req = 1'b0;
        step();
        step();
        check("steal_back_cpu", {63'd0, o_cgnt}, 64'd1);
        check("steal_mem", {48'd0, dut_mem[16'h8000]}, 64'h1234);

        // Burst cap: DMA x4, CPU x1
`ifdef ARB_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
`endif
        dma_req = 1'b1; dma_wen = 1'b0; cpu_wen = 1'b0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            dma_a = 16'(i); cpu_a = 16'(i + 100);
            step();
            check("burst_pattern", {62'd0, o_cgnt, o_dgnt}, (i % 5 == 0) ? 64'd2 : 64'd1);
            stalls += int'(o_stall);
        end
        check("burst_stalls", 64'(stalls), 64'd16);

        // Idle DMA owner drives a read, then CPU gets the bus
        step();
`ifdef ARB_STATS_EN
        check("stats_burst", 64'(o_scnt), 64'd16);
`endif
        dma_req = 1'b0; dma_wen = 1'b1; cpu_req = 1'b0;
        step();
        check("idle_owner", {62'd0, o_dgnt, o_wen}, 64'd2);
        step();
        check("idle_then_cpu", {63'd0, o_cgnt}, 64'd1);
        dma_wen = 1'b0;

`ifdef ARB_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        step();
        check("stats_clr", 64'(o_scnt), 64'd0);
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 82000; i++) step();
        check("stats_sat", 64'(o_scnt), 64'hFFFF);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin pc = $urandom_range(10, 90); pd = $urandom_range(10, 90); end
            rst     = ($urandom_range(0, 299) == 0);
            cpu_req = ($urandom_range(0, 99) < pc);
            dma_req = ($urandom_range(0, 99) < pd);
            cpu_a   = 16'h0100 | 16'($urandom_range(0, 255));
            dma_a   = 16'h0100 | 16'($urandom_range(0, 255));
            cpu_d   = 16'($urandom); dma_d = 16'($urandom);
            cpu_wen = 1'($urandom); dma_wen = 1'($urandom);
            cpu_iom = 1'($urandom); dma_iom = 1'($urandom);
            step();
        end
        rst = 1'b0;
        nmis = 0;
        for (int i = 0; i < 65536; i++) if (dut_mem[i] !== exp_mem[i]) nmis++;
        check("mem_final", 64'(nmis), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
